// File: rtl/uart_tx_arbiter.sv
// Purpose: arbitrates NUM_REQ byte sources onto one uart_tx launch port (round-robin if UART_ARB_RR_EN, else fixed priority).
// Latency: accept to tx_valid is 1 cycle; next accept no sooner than FRAME_CYCLES+GAP_CYCLES+2 cycles later.
// Backpressure: req_ready is a combinational one-hot strobe raised only in IDLE; requesters hold req_valid until served.
module uart_tx_arbiter #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int DATA_BIT   = 8,
  parameter int STOP_BIT   = 1,
  parameter int CHECK_BIT  = 0,
  parameter int GAP_CYCLES = 0,
  parameter int NUM_REQ    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int BIT_CYCLES   = CLK_FREQ / BAUD_RATE;
  localparam int FRAME_CYCLES = BIT_CYCLES * (1 + DATA_BIT + CHECK_BIT + STOP_BIT);
  localparam int WAIT_LOAD    = FRAME_CYCLES + GAP_CYCLES - 1;
  localparam int CNT_W        = (WAIT_LOAD > 0) ? $clog2(WAIT_LOAD + 1) : 1;
  localparam int GW           = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    win_idx;
  logic             win_found;
  logic             accept;
  logic [7:0]       sel_byte;

`ifdef UART_ARB_RR_EN
  logic [GW-1:0] ptr;
  logic [GW-1:0] cand;

  // Round-robin search: first pending requester at or after ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = GW'((int'(ptr) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer moves one past the winner on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (win_idx == GW'(NUM_REQ - 1)) ? '0 : win_idx + GW'(1);
    end
  end
`else
  // Fixed priority: the lowest pending index wins.
  always_comb begin
    win_found = |req_valid;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) win_idx = GW'(k);
    end
  end
`endif

  // Byte lane of the current winner.
  always_comb begin
    sel_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (GW'(k) == win_idx) sel_byte = req_data[8*k +: 8];
    end
  end

  // Next-state and handshake outputs; reset masks ready, busy and launch.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    tx_valid  = 1'b0;
    accept    = 1'b0;
    busy      = (state != IDLE) && !rst;
    case (state)
      IDLE: begin
        if (win_found && !rst) begin
          accept             = 1'b1;
          req_ready[win_idx] = 1'b1;
          state_nxt          = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_valid  = !rst;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Byte capture on accept, frame-wait down-counter loaded at launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= '0;
      grant_id <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        tx_data  <= sel_byte;
        grant_id <= win_idx;
      end
      if (state == LAUNCH) begin
        cnt <= CNT_W'(WAIT_LOAD);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at 8 clocks/bit, 4 requesters, no gap (80-cycle frame).
// Inputs change 1 time unit after a rising edge; outputs are sampled before the next edge.
// Expected values are hand-derived constants; contention expectations follow the arbitration build option.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [1:0]  grant_id;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_arbiter #(
    .CLK_FREQ  (8_000_000),
    .BAUD_RATE (1_000_000),
    .DATA_BIT  (8),
    .STOP_BIT  (1),
    .CHECK_BIT (0),
    .GAP_CYCLES(0),
    .NUM_REQ   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int gap;
    int exp_id;
    logic [7:0] mid;

    // Reset with every requester pending: nothing may be granted.
    rst = 1'b1; req_valid = 4'hF; req_data = 32'h0;
    tick(); tick();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    rst = 1'b0; req_valid = 4'h0;
    tick();

    // Single request, byte 0x5A from requester 0.
    req_valid = 4'b0001; req_data = 32'h0000_005A; #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    tick(); req_valid = 4'b0000; #1;
    chk("t1_txv", 32'(tx_valid), 32'd1);
    chk("t1_txd", 32'(tx_data), 32'h5A);
    chk("t1_gid", 32'(grant_id), 32'd0);
    chk("t1_busy_launch", 32'(busy), 32'd1);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (busy === 1'b1 && tx_valid === 1'b0) n++;
    end
    chk("t1_busy_window", n, 32'd80);
    tick();
    chk("t1_idle_at_82", 32'(busy), 32'd0);
    chk("t1_hold", 32'(tx_data), 32'h5A);

    // Back-to-back from requester 2; data change during WAIT must not leak.
    req_valid = 4'b0100; req_data = 32'h0011_0000; #1;
    chk("t2_ready", 32'(req_ready), 32'h4);
    tick();
    chk("t2_txv1", 32'(tx_valid), 32'd1);
    chk("t2_txd1", 32'(tx_data), 32'h11);
    req_data = 32'h0022_0000;
    mid = 8'h00;
    for (gap = 1; gap <= 200; gap++) begin
      tick();
      if (gap == 40) mid = tx_data;
      if (tx_valid === 1'b1) break;
    end
    chk("t2_gap", gap, 32'd82);
    chk("t2_mid_hold", 32'(mid), 32'h11);
    chk("t2_txd2", 32'(tx_data), 32'h22);
    chk("t2_gid", 32'(grant_id), 32'd2);
    req_valid = 4'b0000;
    wait_idle("t2_idle");

    // Contention from a fresh reset, all four requesters pending.
    rst = 1'b1; tick();
    rst = 1'b0; req_valid = 4'hF; req_data = 32'h4433_2211; #1;
    for (int g = 0; g < 5; g++) begin
`ifdef UART_ARB_RR_EN
      exp_id = g % 4;
`else
      exp_id = 0;
`endif
      chk("t3_ready", 32'(req_ready), 32'h1 << exp_id);
      tick();
      chk("t3_gid", 32'(grant_id), exp_id);
      chk("t3_txd", 32'(tx_data), 32'(17 * (exp_id + 1)));
      wait_idle("t3_idle");
    end
    req_valid = 4'b0000;
    tick();

    // Reset 30 cycles into the wait, requester 2 holding valid.
    req_valid = 4'b0100; req_data = 32'h0077_0000; #1;
    chk("t4_ready", 32'(req_ready), 32'h4);
    tick();
    chk("t4_txv", 32'(tx_valid), 32'd1);
    repeat (30) tick();
    chk("t4_busy_wait", 32'(busy), 32'd1);
    rst = 1'b1; #1;
    chk("t4_busy_rst", 32'(busy), 32'd0);
    chk("t4_ready_rst", 32'(req_ready), 32'd0);
    tick();
    chk("t4_busy_rst2", 32'(busy), 32'd0);
    chk("t4_txd_rst", 32'(tx_data), 32'd0);
    chk("t4_gid_rst", 32'(grant_id), 32'd0);
    rst = 1'b0; #1;
    chk("t4_ready_after", 32'(req_ready), 32'h4);
    tick();
    chk("t4_txv_after", 32'(tx_valid), 32'd1);
    chk("t4_txd_after", 32'(tx_data), 32'h77);
    req_valid = 4'b0000;
    wait_idle("t4_idle");

    // Requester 1 raises valid during WAIT: ignored until IDLE.
    req_valid = 4'b0001; req_data = 32'h0000_00A5; #1;
    chk("t5_ready0", 32'(req_ready), 32'h1);
    tick(); req_valid = 4'b0000;
    tick(); tick();
    req_valid = 4'b0010; req_data = 32'h0000_C300; #1;
    n = 0;
    for (gap = 1; gap <= 200; gap++) begin
      if (busy !== 1'b1) break;
      if (req_ready !== 4'b0000) n++;
      tick();
    end
    chk("t5_ready_during_wait", n, 32'd0);
    chk("t5_ready_idle", 32'(req_ready), 32'h2);
    tick();
    chk("t5_txv", 32'(tx_valid), 32'd1);
    chk("t5_txd", 32'(tx_data), 32'hC3);
    chk("t5_gid", 32'(grant_id), 32'd1);
    req_valid = 4'b0000;
    wait_idle("t5_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
